mem_port_arbiter: RTL and testbench

Shares one single-port, word-wide synchronous-read data memory between the pipeline's instruction-fetch port and its load/store port. Grants at most one access per cycle, with data-port priority and a bounded-starvation guarantee for fetch. Tracks the outstanding read so the response returns to the right requester. For the data port it performs byte-lane steering on stores and extraction with sign/zero extension on loads, so the memory behind it sees only word addresses, byte masks and raw words.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, word-wide, synchronous-read data memory between the
// instruction-fetch port and the load/store port. At most one access is granted
// per cycle. The data port has priority, but fetch is forced to win once it has
// lost STARVE_LIMIT consecutive contended cycles. A one-entry pending tag routes
// the read response (one cycle after grant) back to its owner. Data stores are
// lane-steered into a byte mask and replicated word. Data loads are extracted by
// byte offset and sign/zero extended. Misaligned or illegal-funct3 data accesses
// are granted, never reach memory, and return an error response.
//
// Ports
//   i_clk, i_reset             clock (rising edge), async active-high reset
//   i_if_req/i_if_addr         fetch read request, word-aligned byte address
//   o_if_gnt                   fetch accepted this cycle (combinational)
//   o_if_rvalid/o_if_rdata     fetch response, raw word
//   i_dm_req/we/addr/wdata     data request, store flag, byte address, store data
//   i_dm_funct3                RV32I width code (B, H, W, BU, HU)
//   o_dm_gnt                   data accepted this cycle (combinational)
//   o_dm_rvalid/rdata/err      load data or error response
//   o_mem_ren/wren             memory read/write strobes
//   o_mem_addr/bmask/wdata     word address, byte-lane enables, steered store data
//   i_mem_rdata                memory word, valid the cycle after o_mem_ren

module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [31:0]       i_dm_addr,
    input  logic [31:0]       i_dm_wdata,
    input  logic [2:0]        i_dm_funct3,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [31:0]       o_dm_rdata,
    output logic              o_dm_err,
    output logic              o_mem_ren,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_bmask,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Pending read tag: owner (1 = data port), error flag, byte offset, width code.
    logic       pend_valid_q, pend_valid_d;
    logic       pend_dm_q, pend_dm_d;
    logic       pend_err_q, pend_err_d;
    logic [1:0] pend_off_q, pend_off_d;
    logic [2:0] pend_f3_q, pend_f3_d;

    logic if_req_v, dm_req_v;
    logic if_win, dm_win;
    logic dm_legal, dm_go;

    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Bits of the byte addresses that never reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+2], i_if_addr[1:0],
                                i_dm_addr[31:ADDR_W+2]};

    // Arbitration, legality and memory-side drive.
    always_comb begin
        // Requests are masked during reset so every output reads 0.
        if_req_v = i_if_req & ~i_reset;
        dm_req_v = i_dm_req & ~i_reset;

        if_win = if_req_v & (~dm_req_v | (starve_cnt_q == LIMIT));
        dm_win = dm_req_v & ~if_win;

        unique case (i_dm_funct3)
            3'b000, 3'b100: dm_legal = 1'b1;
            3'b001, 3'b101: dm_legal = ~i_dm_addr[0];
            3'b010:         dm_legal = (i_dm_addr[1:0] == 2'b00);
            default:        dm_legal = 1'b0;
        endcase

        dm_go = dm_win & dm_legal;

        o_if_gnt    = if_win;
        o_dm_gnt    = dm_win;
        o_mem_ren   = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = '0;
        o_mem_bmask = 4'b0000;
        o_mem_wdata = 32'h0;

        if (if_win) begin
            o_mem_ren  = 1'b1;
            o_mem_addr = i_if_addr[ADDR_W+1:2];
        end else if (dm_go) begin
            o_mem_addr = i_dm_addr[ADDR_W+1:2];
            if (i_dm_we) begin
                o_mem_wren = 1'b1;
                // Only B/H/W survive legality for stores; bit 2 is ignored.
                case (i_dm_funct3[1:0])
                    2'b00: begin
                        o_mem_bmask = 4'b0001 << i_dm_addr[1:0];
                        o_mem_wdata = {4{i_dm_wdata[7:0]}};
                    end
                    2'b01: begin
                        o_mem_bmask = 4'b0011 << i_dm_addr[1:0];
                        o_mem_wdata = {2{i_dm_wdata[15:0]}};
                    end
                    default: begin
                        o_mem_bmask = 4'b1111;
                        o_mem_wdata = i_dm_wdata;
                    end
                endcase
            end else begin
                o_mem_ren = 1'b1;
            end
        end
    end

    // Starvation counter and pending-tag next state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_v || if_win) begin
            starve_cnt_d = 4'd0;
        end else if (dm_win && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // Legal stores are fire-and-forget; everything else gets a response.
        pend_valid_d = if_win | (dm_win & (~dm_legal | ~i_dm_we));
        pend_dm_d    = dm_win;
        pend_err_d   = dm_win & ~dm_legal;
        pend_off_d   = i_dm_addr[1:0];
        pend_f3_d    = i_dm_funct3;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt_q <= 4'd0;
            pend_valid_q <= 1'b0;
            pend_dm_q    <= 1'b0;
            pend_err_q   <= 1'b0;
            pend_off_q   <= 2'b00;
            pend_f3_q    <= 3'b000;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_dm_q    <= pend_dm_d;
            pend_err_q   <= pend_err_d;
            pend_off_q   <= pend_off_d;
            pend_f3_q    <= pend_f3_d;
        end
    end

    // Response steering and load extraction.
    always_comb begin
        shifted = i_mem_rdata >> {pend_off_q, 3'b000};

        case (pend_f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = i_mem_rdata;
        endcase

        o_if_rvalid = pend_valid_q & ~pend_dm_q;
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
        o_dm_rvalid = pend_valid_q & pend_dm_q;
        o_dm_err    = o_dm_rvalid & pend_err_q;
        o_dm_rdata  = (o_dm_rvalid && !pend_err_q) ? load_ext : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A byte-addressed reference memory
// and a per-cycle model of the arbitration rules predict grants, memory strobes
// and responses; directed sequences cover the listed scenarios, then a long
// randomized run exercises contention, drops, stores, loads and bad accesses.

module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned LIMIT  = 4;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_if_req;
    logic [31:0]       i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [31:0]       o_if_rdata;
    logic              i_dm_req;
    logic              i_dm_we;
    logic [31:0]       i_dm_addr;
    logic [31:0]       i_dm_wdata;
    logic [2:0]        i_dm_funct3;
    logic              o_dm_gnt;
    logic              o_dm_rvalid;
    logic [31:0]       o_dm_rdata;
    logic              o_dm_err;
    logic              o_mem_ren;
    logic              o_mem_wren;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [3:0]        o_mem_bmask;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_dm_req    (i_dm_req),
        .i_dm_we     (i_dm_we),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .i_dm_funct3 (i_dm_funct3),
        .o_dm_gnt    (o_dm_gnt),
        .o_dm_rvalid (o_dm_rvalid),
        .o_dm_rdata  (o_dm_rdata),
        .o_dm_err    (o_dm_err),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wren  (o_mem_wren),
        .o_mem_addr  (o_mem_addr),
        .o_mem_bmask (o_mem_bmask),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Memory seen by the DUT: 64 words, written by DUT strobes or bench preload.
    logic [31:0] dut_mem [0:63];
    logic        tb_we;
    logic [5:0]  tb_waddr;
    logic [31:0] tb_wdata;

    always @(posedge i_clk) begin
        if (o_mem_wren) begin
            for (int l = 0; l < 4; l++)
                if (o_mem_bmask[l]) dut_mem[o_mem_addr[5:0]][8*l +: 8] <= o_mem_wdata[8*l +: 8];
        end else if (tb_we) begin
            dut_mem[tb_waddr] <= tb_wdata;
        end
        if (o_mem_ren) i_mem_rdata <= dut_mem[o_mem_addr[5:0]];
    end

    // Reference model state.
    logic [7:0]  mb [0:255];
    int          sc;
    int          exp_kind;    // 0 none, 1 fetch, 2 data
    logic        exp_err;
    logic [31:0] exp_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations kept for the directed constant checks.
    logic        last_if_gnt, last_dm_gnt;
    logic        obs_if_gnt, obs_dm_gnt, obs_ren, obs_dm_rvalid, obs_dm_err, obs_if_rvalid;
    logic [31:0] obs_if_rdata, obs_dm_rdata, obs_wdata, obs_addr;
    logic [3:0]  obs_bmask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] f3, input logic [7:0] a);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return a[0] == 1'b0;
            3'b010:         return a[1:0] == 2'b00;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {mb[b + 8'd3], mb[b + 8'd2], mb[b + 8'd1], mb[b]};
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [7:0] a);
        logic [7:0] lo, hi;
        lo = mb[a];
        hi = mb[a + 8'd1];
        case (f3)
            3'b000:  return {{24{lo[7]}}, lo};
            3'b100:  return {24'h0, lo};
            3'b001:  return {{16{hi[7]}}, hi, lo};
            3'b101:  return {16'h0, hi, lo};
            default: return rd_word(a);
        endcase
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        for (int k = 0; k < 4; k++) mb[4*w + k] = v[8*k +: 8];
        tb_we    = 1'b1;
        tb_waddr = 6'(w);
        tb_wdata = v;
        @(posedge i_clk);
        #1;
        tb_we = 1'b0;
    endtask

    // One clock of stimulus: drive at posedge+1, check at negedge, advance model.
    task automatic drive_cycle(input bit ifr, input logic [31:0] ifa, input bit dmr,
                               input bit we, input logic [31:0] da, input logic [31:0] wd,
                               input logic [2:0] f3);
        bit          eg_if, eg_dm, ok;
        logic        e_ren, e_wren;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_bmask;
        logic [7:0]  a8;

        i_if_req    = ifr;
        i_if_addr   = ifa;
        i_dm_req    = dmr;
        i_dm_we     = we;
        i_dm_addr   = da;
        i_dm_wdata  = wd;
        i_dm_funct3 = f3;
        #4;

        a8    = da[7:0];
        eg_if = ifr && (!dmr || sc == int'(LIMIT));
        eg_dm = dmr && !eg_if;
        ok    = eg_dm && legal(f3, a8);

        e_ren = 1'b0; e_wren = 1'b0; e_addr = 32'h0; e_bmask = 4'h0; e_wdata = 32'h0;
        if (eg_if) begin
            e_ren  = 1'b1;
            e_addr = 32'(ifa[15:2]);
        end else if (ok) begin
            e_addr = 32'(da[15:2]);
            if (!we) begin
                e_ren = 1'b1;
            end else begin
                e_wren = 1'b1;
                case (f3)
                    3'b000, 3'b100: begin e_bmask = 4'b0001 << da[1:0]; e_wdata = {4{wd[7:0]}}; end
                    3'b001, 3'b101: begin e_bmask = 4'b0011 << da[1:0]; e_wdata = {2{wd[15:0]}}; end
                    default:        begin e_bmask = 4'b1111; e_wdata = wd; end
                endcase
            end
        end

        check("if_gnt",    32'(o_if_gnt),    32'(eg_if));
        check("dm_gnt",    32'(o_dm_gnt),    32'(eg_dm));
        check("mem_ren",   32'(o_mem_ren),   32'(e_ren));
        check("mem_wren",  32'(o_mem_wren),  32'(e_wren));
        check("mem_addr",  32'(o_mem_addr),  e_addr);
        check("mem_bmask", 32'(o_mem_bmask), 32'(e_bmask));
        check("mem_wdata", o_mem_wdata,      e_wdata);
        check("if_rvalid", 32'(o_if_rvalid), 32'(exp_kind == 1));
        check("dm_rvalid", 32'(o_dm_rvalid), 32'(exp_kind == 2));
        check("dm_err",    32'(o_dm_err),    32'(exp_kind == 2 && exp_err));
        check("if_rdata",  o_if_rdata,       (exp_kind == 1) ? exp_data : 32'h0);
        check("dm_rdata",  o_dm_rdata,       (exp_kind == 2) ? exp_data : 32'h0);

        obs_if_gnt = o_if_gnt; obs_dm_gnt = o_dm_gnt; obs_ren = o_mem_ren;
        obs_addr = 32'(o_mem_addr); obs_bmask = o_mem_bmask; obs_wdata = o_mem_wdata;
        obs_if_rvalid = o_if_rvalid; obs_if_rdata = o_if_rdata;
        obs_dm_rvalid = o_dm_rvalid; obs_dm_err = o_dm_err; obs_dm_rdata = o_dm_rdata;
        last_if_gnt = eg_if; last_dm_gnt = eg_dm;

        @(posedge i_clk);
        exp_kind = 0; exp_err = 1'b0; exp_data = 32'h0;
        if (eg_if) begin
            exp_kind = 1;
            exp_data = rd_word(ifa[7:0]);
        end else if (eg_dm) begin
            if (!legal(f3, a8)) begin
                exp_kind = 2;
                exp_err  = 1'b1;
            end else if (!we) begin
                exp_kind = 2;
                exp_data = load_val(f3, a8);
            end else begin
                mb[a8] = wd[7:0];
                if (f3[1:0] != 2'b00) mb[a8 + 8'd1] = wd[15:8];
                if (f3 == 3'b010) begin
                    mb[a8 + 8'd2] = wd[23:16];
                    mb[a8 + 8'd3] = wd[31:24];
                end
            end
        end
        if (!ifr || eg_if) sc = 0;
        else if (eg_dm && sc < int'(LIMIT)) sc++;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnts"},   32'({o_if_gnt, o_dm_gnt}), 32'h0);
        check({tag, "_rvalid"}, 32'({o_if_rvalid, o_dm_rvalid, o_dm_err}), 32'h0);
        check({tag, "_rdata"},  o_if_rdata | o_dm_rdata, 32'h0);
        check({tag, "_mem"},    32'({o_mem_ren, o_mem_wren, o_mem_bmask}), 32'h0);
        check({tag, "_maddr"},  32'(o_mem_addr) | o_mem_wdata, 32'h0);
    endtask

    logic [2:0]  legal_tab [0:4];
    logic [9:0]  gnt_seq;
    bit          r_if_req, r_dm_req, r_we;
    logic [31:0] r_if_addr, r_dm_addr, r_wd;
    logic [2:0]  r_f3;

    initial begin
        legal_tab[0] = 3'b000; legal_tab[1] = 3'b001; legal_tab[2] = 3'b010;
        legal_tab[3] = 3'b100; legal_tab[4] = 3'b101;
        sc = 0; exp_kind = 0; exp_err = 1'b0; exp_data = 32'h0;
        tb_we = 1'b0; tb_waddr = 6'h0; tb_wdata = 32'h0;
        i_reset = 1'b1;
        i_if_req = 1'b0; i_if_addr = 32'h0; i_dm_req = 1'b0; i_dm_we = 1'b0;
        i_dm_addr = 32'h0; i_dm_wdata = 32'h0; i_dm_funct3 = 3'b000;

        // Preload memory while in reset, then check the reset state.
        for (int w = 0; w < 64; w++) begin
            if (w == 4)      set_word(w, 32'hDEAD_BEEF);
            else if (w == 8) set_word(w, 32'h8070_F0A5);
            else             set_word(w, $urandom);
        end
        #4;
        check_quiet("reset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Fetch only.
        drive_cycle(1, 32'h0000_0010, 0, 0, 0, 0, 3'b000);
        check("fetch_gnt",  32'(obs_if_gnt), 32'h1);
        check("fetch_addr", obs_addr, 32'h4);
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);
        check("fetch_rdata", obs_if_rdata, 32'hDEAD_BEEF);

        // Back-to-back data loads.
        drive_cycle(0, 0, 1, 0, 32'h23, 0, 3'b000);
        drive_cycle(0, 0, 1, 0, 32'h21, 0, 3'b100);
        check("lb",  obs_dm_rdata, 32'hFFFF_FF80);
        drive_cycle(0, 0, 1, 0, 32'h22, 0, 3'b001);
        check("lbu", obs_dm_rdata, 32'h0000_00F0);
        drive_cycle(0, 0, 1, 0, 32'h20, 0, 3'b101);
        check("lh",  obs_dm_rdata, 32'hFFFF_8070);
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);
        check("lhu", obs_dm_rdata, 32'h0000_F0A5);

        // Stores.
        drive_cycle(0, 0, 1, 1, 32'h31, 32'h0000_00AB, 3'b000);
        check("sb_bmask", 32'(obs_bmask), 32'h2);
        check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        drive_cycle(0, 0, 1, 1, 32'h32, 32'h0000_1234, 3'b001);
        check("sh_bmask", 32'(obs_bmask), 32'hC);
        check("sh_wdata", obs_wdata, 32'h1234_1234);
        check("sb_norsp", 32'({obs_if_rvalid, obs_dm_rvalid}), 32'h0);
        drive_cycle(0, 0, 1, 0, 32'h30, 0, 3'b010);
        check("sh_norsp", 32'({obs_if_rvalid, obs_dm_rvalid}), 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);

        // Contention: both held for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 32'h4, 1, 0, 32'h20, 0, 3'b010);
            gnt_seq[i] = obs_if_gnt;
        end
        check("starve_pattern", 32'(gnt_seq), 32'h210);
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);

        // Misaligned word load.
        drive_cycle(0, 0, 1, 0, 32'h42, 0, 3'b010);
        check("mis_gnt", 32'(obs_dm_gnt), 32'h1);
        check("mis_ren", 32'(obs_ren), 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);
        check("mis_rsp", 32'({obs_dm_rvalid, obs_dm_err}), 32'h3);
        check("mis_rdata", obs_dm_rdata, 32'h0);

        // Randomized traffic.
        r_if_req = 0; r_dm_req = 0; r_we = 0;
        r_if_addr = 0; r_dm_addr = 0; r_wd = 0; r_f3 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!r_if_req || last_if_gnt) begin
                r_if_req  = ($urandom_range(3) != 0);
                r_if_addr = {16'($urandom), 8'h00, 6'($urandom), 2'b00};
            end else if ($urandom_range(19) == 0) begin
                r_if_req = 0;
            end
            if (!r_dm_req || last_dm_gnt) begin
                r_dm_req  = ($urandom_range(2) != 0);
                r_we      = ($urandom_range(2) == 0);
                r_f3      = ($urandom_range(4) == 0) ? 3'($urandom_range(7))
                                                     : legal_tab[$urandom_range(4)];
                r_dm_addr = {16'($urandom), 8'h00, 8'($urandom)};
                if ($urandom_range(1) == 0) r_dm_addr[1:0] = 2'b00;
                r_wd      = $urandom;
            end else if ($urandom_range(19) == 0) begin
                r_dm_req = 0;
            end
            if (!r_if_req && !r_dm_req) last_if_gnt = 0;
            drive_cycle(r_if_req, r_if_addr, r_dm_req, r_we, r_dm_addr, r_wd, r_f3);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);

        // Reset with a fetch read pending.
        drive_cycle(1, 32'h0000_0010, 0, 0, 0, 0, 3'b000);
        i_reset  = 1'b1;
        i_if_req = 1'b1;
        i_dm_req = 1'b1;
        #4;
        check_quiet("rst_pend");
        @(posedge i_clk);
        #1;
        i_reset  = 1'b0;
        sc       = 0;
        exp_kind = 0;
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);
        check("rst_no_rvalid", 32'(obs_if_rvalid), 32'h0);
        drive_cycle(0, 0, 0, 0, 0, 0, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
